// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one memory line port shared by the icache refill path and
// the dcache read / write-back path. A single owner holds the port at a time.
// Pending write-backs win over reads, and I/D reads alternate round-robin.
// A watchdog releases the port when memory never answers.
module mem_port_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  input  logic              d_wreq,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_wack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rready,
  input  logic              mem_wack,
  output logic              busy,
  output logic [1:0]        owner,
  output logic              mem_error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_D_WR = 3'd1;
  localparam logic [2:0] S_D_RD = 3'd2;
  localparam logic [2:0] S_I_RD = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [2:0]        r_state;
  logic              r_rr_last;   // 0 = icache served last, 1 = dcache
  logic [WD_W-1:0]   r_wd_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              r_i_ready;
  logic              r_d_ready;
  logic              r_d_wack;
  logic [1:0]        r_owner;
  logic              r_mem_error;

  logic [2:0]        w_sel;
  logic              w_wait;
  logic              w_got_wr;
  logic              w_got_rd;
  logic              w_timeout;

  // Responses only count when they match the kind of transaction in flight.
  assign w_wait    = (r_state == S_D_WR) || (r_state == S_D_RD) || (r_state == S_I_RD);
  assign w_got_wr  = (r_state == S_D_WR) && mem_wack;
  assign w_got_rd  = ((r_state == S_D_RD) || (r_state == S_I_RD)) && mem_rready;
  assign w_timeout = (TIMEOUT > 0) && w_wait && !w_got_wr && !w_got_rd
                     && (r_wd_cnt == WD_LAST);

  // Next owner choice in IDLE: write-back first, then round-robin reads.
  always_comb begin
    w_sel = S_IDLE;
    if (d_wreq) begin
      w_sel = S_D_WR;
    end else if (d_req && i_req) begin
      w_sel = r_rr_last ? S_I_RD : S_D_RD;
    end else if (d_req) begin
      w_sel = S_D_RD;
    end else if (i_req) begin
      w_sel = S_I_RD;
    end
  end

  // Owner FSM, memory request registers, response capture and watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_last   <= 1'b0;
      r_wd_cnt    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_d_wack    <= 1'b0;
      r_owner     <= 2'd0;
      r_mem_error <= 1'b0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_d_wack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sel != S_IDLE) begin
            r_state     <= w_sel;
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_sel == S_D_WR);
            r_mem_wdata <= d_wdata;
            r_wd_cnt    <= '0;
            if (w_sel == S_D_WR) begin
              r_mem_addr <= d_waddr;
              r_owner    <= 2'd3;
            end else if (w_sel == S_D_RD) begin
              r_mem_addr <= d_addr;
              r_owner    <= 2'd2;
            end else begin
              r_mem_addr <= i_addr;
              r_owner    <= 2'd1;
            end
          end
        end
        S_D_WR, S_D_RD, S_I_RD: begin
          if (w_got_wr || w_got_rd || w_timeout) begin
            r_mem_req <= 1'b0;
            r_state   <= S_RESP;
            if (w_timeout) begin
              r_mem_error <= 1'b1;
            end
            if (r_state == S_D_WR) begin
              r_d_wack <= 1'b1;
            end else if (r_state == S_D_RD) begin
              r_d_ready <= 1'b1;
              if (w_got_rd) begin
                r_d_rdata <= mem_rdata;
                r_rr_last <= 1'b1;
              end
            end else begin
              r_i_ready <= 1'b1;
              if (w_got_rd) begin
                r_i_rdata <= mem_rdata;
                r_rr_last <= 1'b0;
              end
            end
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        S_RESP: begin
          // Dead cycle so requesters can drop their request before re-arbitration.
          r_owner <= 2'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_owner   <= 2'd0;
        end
      endcase
    end
  end

  assign i_rdata   = r_i_rdata;
  assign i_ready   = r_i_ready;
  assign d_rdata   = r_d_rdata;
  assign d_ready   = r_d_ready;
  assign d_wack    = r_d_wack;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;
  assign mem_error = r_mem_error;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-programmable
// memory responder plus manual stray-response drivers.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 26;
  localparam int LINE_W = 128;

  logic              clk;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_rdata;
  logic              d_ready;
  logic              d_wreq;
  logic [ADDR_W-1:0] d_waddr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_wack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_rready;
  logic              mem_wack;
  logic              busy;
  logic [1:0]        owner;
  logic              mem_error;

  // memory responder state
  logic              mdl_en;
  int                mdl_lat;
  int                mdl_cnt;
  logic              mdl_done;
  logic              mdl_rready;
  logic              mdl_wack;
  logic              man_rready;
  logic              man_wack;

  int n_total;
  int n_bad;

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] pat_5a;
  logic [LINE_W-1:0] pat_wr;
  logic [LINE_W-1:0] pat_c3;
  int n;

  assign mem_rready = mdl_rready | man_rready;
  assign mem_wack   = mdl_wack | man_wack;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_addr(d_addr), .d_rdata(d_rdata), .d_ready(d_ready),
    .d_wreq(d_wreq), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wack(d_wack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rready(mem_rready), .mem_wack(mem_wack),
    .busy(busy), .owner(owner), .mem_error(mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: answers in the mdl_lat-th cycle that mem_req is high.
  always @(negedge clk) begin
    if (mdl_en && mem_req && !mdl_done) begin
      mdl_cnt <= mdl_cnt + 1;
      if (mdl_cnt + 1 == mdl_lat) begin
        mdl_done <= 1'b1;
        if (mem_we) mdl_wack <= 1'b1;
        else        mdl_rready <= 1'b1;
      end
    end else begin
      mdl_rready <= 1'b0;
      mdl_wack   <= 1'b0;
      if (!mem_req) begin
        mdl_cnt  <= 0;
        mdl_done <= 1'b0;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  function automatic logic sig_of(input int s);
    case (s)
      0:       return i_ready;
      1:       return d_ready;
      2:       return d_wack;
      default: return mem_req;
    endcase
  endfunction

  // Tick until the selected signal is high or the budget runs out.
  task automatic wait_for(input int s, input int max, output int cnt);
    cnt = 0;
    while (!sig_of(s) && cnt < max) begin
      tick();
      cnt++;
    end
    check($sformatf("wait_sig%0d_seen", s), 128'(sig_of(s)), 128'd1);
  endtask

  initial begin
    pat_a5 = {16{8'hA5}};
    pat_5a = {16{8'h5A}};
    pat_wr = 128'h123456789ABCDEF0_0FEDCBA987654321;
    pat_c3 = {16{8'hC3}};
    n_total = 0; n_bad = 0;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
    d_wreq = 1'b0; d_waddr = '0; d_wdata = '0;
    mem_rdata = '0; man_rready = 1'b0; man_wack = 1'b0;
    mdl_en = 1'b1; mdl_lat = 1; mdl_cnt = 0; mdl_done = 1'b0;
    mdl_rready = 1'b0; mdl_wack = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_mem_req", 128'(mem_req), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_owner", 128'(owner), 128'd0);
    check("rst_i_rdata", i_rdata, 128'd0);
    check("rst_d_rdata", d_rdata, 128'd0);
    check("rst_pulses", 128'({i_ready, d_ready, d_wack, mem_error, mem_we}), 128'd0);
    check("rst_mem_addr", 128'(mem_addr), 128'd0);
    check("rst_mem_wdata", mem_wdata, 128'd0);
    reset = 1'b0;
    tick();

    // single icache read, memory latency 3
    mdl_lat = 3; mem_rdata = pat_a5; i_addr = 26'h0000010; i_req = 1'b1;
    tick();
    check("a_mem_req", 128'(mem_req), 128'd1);
    check("a_mem_addr", 128'(mem_addr), 128'h10);
    check("a_mem_we", 128'(mem_we), 128'd0);
    check("a_owner", 128'(owner), 128'd1);
    check("a_busy", 128'(busy), 128'd1);
    wait_for(0, 20, n);
    check("a_latency", 128'(n), 128'd3);
    check("a_i_rdata", i_rdata, pat_a5);
    check("a_mem_req_drop", 128'(mem_req), 128'd0);
    i_req = 1'b0;
    tick();
    check("a_i_ready_once", 128'(i_ready), 128'd0);
    check("a_owner_clear", 128'(owner), 128'd0);
    check("a_busy_clear", 128'(busy), 128'd0);

    // watchdog: silent memory on an icache read
    mdl_en = 1'b0; i_addr = 26'h0000030; i_req = 1'b1;
    tick();
    check("t_mem_req", 128'(mem_req), 128'd1);
    n = 1;
    while (mem_req && n < 40) begin
      tick();
      if (mem_req) n++;
    end
    check("t_wait_cycles", 128'(n), 128'd8);
    check("t_i_ready", 128'(i_ready), 128'd1);
    check("t_i_rdata_kept", i_rdata, pat_a5);
    check("t_mem_error", 128'(mem_error), 128'd1);
    i_req = 1'b0;
    tick();
    check("t_error_sticky", 128'(mem_error), 128'd1);
    mdl_en = 1'b1; mdl_lat = 1; mem_rdata = pat_5a; d_addr = 26'h0000044; d_req = 1'b1;
    wait_for(3, 10, n);
    check("t2_owner", 128'(owner), 128'd2);
    check("t2_mem_addr", 128'(mem_addr), 128'h44);
    wait_for(1, 10, n);
    check("t2_d_rdata", d_rdata, pat_5a);
    d_req = 1'b0;
    check("t2_error_still", 128'(mem_error), 128'd1);

    // round robin from reset: D, I, D, I
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("b_error_cleared", 128'(mem_error), 128'd0);
    check("b_d_rdata_cleared", d_rdata, 128'd0);
    mem_rdata = pat_a5; d_addr = 26'h0000200; i_addr = 26'h0000100;
    d_req = 1'b1; i_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_for(3, 10, n);
      check($sformatf("b%0d_gap", k), 128'(n), (k == 0) ? 128'd1 : 128'd2);
      check($sformatf("b%0d_owner", k), 128'(owner), (k % 2 == 0) ? 128'd2 : 128'd1);
      check($sformatf("b%0d_addr", k), 128'(mem_addr), (k % 2 == 0) ? 128'h200 : 128'h100);
      wait_for((k % 2 == 0) ? 1 : 0, 10, n);
      check($sformatf("b%0d_lat", k), 128'(n), 128'd1);
    end
    check("b_d_rdata", d_rdata, pat_a5);
    d_req = 1'b0; i_req = 1'b0;
    tick();
    tick();

    // write-back and read raised together: write first
    d_wreq = 1'b1; d_waddr = 26'h3FFFFFF; d_wdata = pat_wr;
    d_req = 1'b1; d_addr = 26'h0000020; mem_rdata = pat_c3;
    wait_for(3, 10, n);
    check("c_we", 128'(mem_we), 128'd1);
    check("c_addr", 128'(mem_addr), 128'h3FFFFFF);
    check("c_wdata", mem_wdata, pat_wr);
    check("c_owner", 128'(owner), 128'd3);
    wait_for(2, 10, n);
    check("c_wack_lat", 128'(n), 128'd1);
    check("c_no_d_ready", 128'(d_ready), 128'd0);
    d_wreq = 1'b0;
    wait_for(3, 10, n);
    check("c_rd_we", 128'(mem_we), 128'd0);
    check("c_rd_addr", 128'(mem_addr), 128'h20);
    check("c_rd_owner", 128'(owner), 128'd2);
    wait_for(1, 10, n);
    check("c_d_rdata", d_rdata, pat_c3);
    d_req = 1'b0;
    tick();

    // reset two cycles into a dcache read
    mdl_en = 1'b0; d_addr = 26'h0000040; d_req = 1'b1;
    wait_for(3, 10, n);
    tick();
    reset = 1'b1; d_req = 1'b0;
    tick();
    reset = 1'b0;
    check("e_mem_req", 128'(mem_req), 128'd0);
    check("e_busy", 128'(busy), 128'd0);
    check("e_no_d_ready", 128'(d_ready), 128'd0);
    mem_rdata = {16{8'hFF}}; man_rready = 1'b1;
    tick();
    man_rready = 1'b0; man_wack = 1'b1;
    check("e_stray_busy", 128'(busy), 128'd0);
    check("e_stray_ready", 128'({i_ready, d_ready}), 128'd0);
    tick();
    man_wack = 1'b0;
    check("e_stray_wack", 128'(d_wack), 128'd0);
    check("e_d_rdata", d_rdata, 128'd0);

    // stray write ack during an icache read
    i_addr = 26'h0000050; i_req = 1'b1;
    wait_for(3, 10, n);
    man_wack = 1'b1;
    tick();
    man_wack = 1'b0;
    check("f_mem_req_held", 128'(mem_req), 128'd1);
    check("f_owner", 128'(owner), 128'd1);
    check("f_no_pulses", 128'({i_ready, d_wack}), 128'd0);
    tick();
    mem_rdata = pat_c3; man_rready = 1'b1;
    tick();
    man_rready = 1'b0; i_req = 1'b0;
    check("f_i_ready", 128'(i_ready), 128'd1);
    check("f_i_rdata", i_rdata, pat_c3);
    check("f_mem_req_drop", 128'(mem_req), 128'd0);
    tick();
    check("f_i_ready_once", 128'(i_ready), 128'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external line-memory port between the instruction cache refill path and the data cache read/write-back path.
- Sits between both caches and the memory model/controller. Serialises transactions through a one-owner FSM:
  - a data-cache write-back always precedes any read;
  - read requests from I and D are granted round-robin.
- A watchdog aborts transactions the memory never acknowledges.

Parameters:
ADDR_W, 26, line address width (32-bit byte address minus 4 offset bits, minus 2 upper bits)
LINE_W, 128, cache line width in bits
TIMEOUT, 255, max cycles a transaction may wait for memory before abort; 0 disables watchdog

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_req  in  1  icache line read request, level, held until i_ready
i_addr  in  ADDR_W  icache line address
i_rdata  out  LINE_W  line returned to icache
i_ready  out  1  one-cycle pulse, i_rdata valid
d_req  in  1  dcache line read request, level, held until d_ready
d_addr  in  ADDR_W  dcache read line address
d_rdata  out  LINE_W  line returned to dcache
d_ready  out  1  one-cycle pulse, d_rdata valid
d_wreq  in  1  dcache write-back request, level, held until d_wack
d_waddr  in  ADDR_W  write-back line address
d_wdata  in  LINE_W  write-back line data
d_wack  out  1  one-cycle pulse, write-back accepted by memory
mem_req  out  1  memory request, held until response
mem_we  out  1  1 = write, 0 = read; stable while mem_req
mem_addr  out  ADDR_W  memory line address; stable while mem_req
mem_wdata  out  LINE_W  memory write data; stable while mem_req
mem_rdata  in  LINE_W  memory read data
mem_rready  in  1  read data valid (single cycle)
mem_wack  in  1  write accepted (single cycle)
busy  out  1  state != IDLE
owner  out  2  0 none, 1 icache, 2 dcache read, 3 dcache write
mem_error  out  1  sticky watchdog flag, cleared only by reset

Behaviour:
- Reset: all outputs 0, including rdata buses. State IDLE. rr_last=I, so D wins the first read tie.
- States: IDLE, D_WR, D_RD, I_RD, RESP.
- IDLE selection, evaluated every cycle:
  - d_wreq → D_WR;
  - else if both reads pending → the one not equal to rr_last;
  - else the single pending read;
  - else stay.
  - On grant: latch addr/wdata/we into output registers; mem_req=1 from the next cycle; owner updated; watchdog cleared.
- D_WR: hold mem_req/mem_we=1. On mem_wack: mem_req→0, d_wack=1 for one cycle, → RESP.
- D_RD / I_RD: hold mem_req, mem_we=0. On mem_rready:
  - capture mem_rdata into d_rdata/i_rdata (held until the next capture);
  - pulse d_ready/i_ready;
  - rr_last = served requester;
  - mem_req→0, → RESP.
- RESP: one dead cycle so requesters can drop req; owner→0; → IDLE. No grant is possible in RESP.
- Minimum latency: request seen in IDLE at cycle t → mem_req high at t+1. With a same-cycle memory response at t+1, the ready pulse is at t+2 and the next grant at t+4 at the earliest.
- Responses from the wrong type are ignored and do not change state: mem_wack during a read, mem_rready during a write, or either in IDLE/RESP.
- Inputs are sampled only at grant. Changes of addr/data while owned are ignored.
- A requester dropping req mid-transaction does not abort it. The response pulse is still issued.
- Watchdog (TIMEOUT>0):
  - counts cycles in D_WR/D_RD/I_RD;
  - on reaching TIMEOUT without a response: mem_req→0, mem_error=1, pulse the owner's ready/ack with rdata unchanged, → RESP.
- Reset mid-transaction: immediate return to IDLE, mem_req=0, no response pulse issued.
- Write-back priority also applies when d_wreq and d_req rise together: write first, then the read via normal arbitration.

Test Plan:
- Only i_req, i_addr=0x0000010; memory responds 3 cycles after mem_req with 128'hA5…A5 → mem_addr=0x0000010, mem_we=0; i_ready one cycle with i_rdata=A5…; owner 1→0.
- i_req and d_req together from reset, memory 1-cycle latency → D served first (owner=2), then I. Repeat with both held → grants alternate D, I, D, I.
- d_wreq (waddr=0x3FFFFFF, wdata=128'h1234…) and d_req(0x0000020) together → write issued first (mem_we=1, addr all ones), d_wack pulse, then read with mem_we=0, d_ready.
- TIMEOUT=8, I read, memory silent → mem_req low after 8 wait cycles; mem_error=1 and stays 1; i_ready pulses; a subsequent d_req completes normally.
- Reset asserted 2 cycles into a D_RD → next cycle mem_req=0, busy=0, no d_ready. Stray mem_rready afterwards is ignored.
- mem_wack pulse during I_RD → no state change. The later mem_rready completes I_RD correctly.
